// File: rtl/even_chk_pkg.sv
// -----------------------------------------------------------------------------
// even_chk_pkg
// Shared definitions for the even-counter stream checker:
//   - state_t      : checker state machine encoding
//   - DEF_MAX_VAL  : default terminal count of the upstream counter
//   - DEF_STEP     : default legal increment
//   - DEF_LOCK_N   : default number of legal advances needed to lock
//   - value_ok()   : true when a sample is a multiple of step and <= max_val
// -----------------------------------------------------------------------------
package even_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int DEF_MAX_VAL = 14;
    localparam int DEF_STEP    = 2;
    localparam int DEF_LOCK_N  = 2;

    // A sample is only meaningful if it lies on the counter's even grid.
    function automatic logic value_ok(input logic [3:0] v,
                                      input int         max_val,
                                      input int         step);
        return ((int'(v) % step) == 0) && (int'(v) <= max_val);
    endfunction

endpackage

// File: rtl/even_step_legal.sv
// -----------------------------------------------------------------------------
// even_step_legal
// Purely combinational classifier for one p -> c transition of the even
// counter stream.
// Ports:
//   p       in  4  previous sample
//   c       in  4  current sample
//   valid   in  1  current sample is being evaluated
//   is_hold out 1  c == p
//   is_adv  out 1  p < MAX_VAL and c == p + STEP
//   is_wrap out 1  p == MAX_VAL and c == 0
//   is_bad  out 1  evaluated sample that is none of the above, or off-grid
// All outputs are 0 when valid is 0.
// -----------------------------------------------------------------------------
module even_step_legal
    import even_chk_pkg::*;
#(
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int STEP    = DEF_STEP
) (
    input  logic [3:0] p,
    input  logic [3:0] c,
    input  logic       valid,
    output logic       is_hold,
    output logic       is_adv,
    output logic       is_wrap,
    output logic       is_bad
);

    // p + STEP is formed in 5 bits so that 14 + 2 = 16 can never alias onto 0
    // and masquerade as an advance.
    logic [4:0] w_sum;
    logic       w_c_ok;

    assign w_sum  = {1'b0, p} + 5'(STEP);
    assign w_c_ok = value_ok(c, MAX_VAL, STEP);

    assign is_hold = valid && (c == p);
    assign is_adv  = valid && (int'(p) < MAX_VAL) && ({1'b0, c} == w_sum);
    assign is_wrap = valid && (int'(p) == MAX_VAL) && (c == 4'd0);
    assign is_bad  = valid && (!w_c_ok || !(is_hold || is_adv || is_wrap));

endmodule

// File: rtl/even_count_checker.sv
// -----------------------------------------------------------------------------
// even_count_checker
// Monitors the 4-bit even counter output, locks after LOCK_N legal advances,
// counts laps (wraps seen while locked) and flags any illegal value or step
// with a sticky error.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      synchronous active-high reset
//   cnt_valid  in  1      cnt_in carries a sample this cycle
//   cnt_in     in  4      upstream counter value
//   clear      in  1      synchronous clear of fault, lock and lap count
//   locked     out 1      checker is in LOCKED
//   error      out 1      sticky fault flag
//   lap_pulse  out 1      one-cycle pulse per counted wrap
//   lap_count  out LAP_W  saturating count of wraps seen while locked
// Optional (macro EVEN_CHK_CAPTURE_EN):
//   err_prev   out 4      previous sample of the first offending transition
//   err_curr   out 4      offending sample of the first offending transition
// All outputs are registered (one cycle after the sample edge).
// -----------------------------------------------------------------------------
module even_count_checker
    import even_chk_pkg::*;
#(
    parameter int LAP_W   = 8,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int STEP    = DEF_STEP,
    parameter int LOCK_N  = DEF_LOCK_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_valid,
    input  logic [3:0]       cnt_in,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_count
`ifdef EVEN_CHK_CAPTURE_EN
    ,
    output logic [3:0]       err_prev,
    output logic [3:0]       err_curr
`endif
);

    localparam logic [2:0] LOCK_N_W = 3'(LOCK_N);

    state_t           r_state;
    logic [3:0]       r_prev;
    logic [2:0]       r_good;
    logic [LAP_W-1:0] r_lap_count;
    logic             r_locked;
    logic             r_error;
    logic             r_lap_pulse;

    logic       w_is_hold;
    logic       w_is_adv;
    logic       w_is_wrap;
    logic       w_is_bad;
    logic       w_val_ok;
    logic       w_to_fault;
    logic [2:0] w_good_inc;

    even_step_legal #(
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_step_legal (
        .p       (r_prev),
        .c       (cnt_in),
        .valid   (cnt_valid),
        .is_hold (w_is_hold),
        .is_adv  (w_is_adv),
        .is_wrap (w_is_wrap),
        .is_bad  (w_is_bad)
    );

    assign w_val_ok   = value_ok(cnt_in, MAX_VAL, STEP);
    assign w_good_inc = r_good + 3'd1;

    // In IDLE there is no meaningful previous value, so only the value grid is
    // checked; in SYNC/LOCKED the full transition rule applies.
    assign w_to_fault = cnt_valid &&
                        (((r_state == IDLE) && !w_val_ok) ||
                         (((r_state == SYNC) || (r_state == LOCKED)) && w_is_bad));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prev      <= 4'd0;
            r_good      <= 3'd0;
            r_lap_count <= '0;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_lap_pulse <= 1'b0;
        end else if (clear) begin
            // clear beats a coincident sample: the sample is dropped.
            r_state     <= IDLE;
            r_prev      <= 4'd0;
            r_good      <= 3'd0;
            r_lap_count <= '0;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_lap_pulse <= 1'b0;
        end else begin
            r_lap_pulse <= 1'b0;
            if (cnt_valid) begin
                r_prev <= cnt_in;
                if (w_to_fault) begin
                    r_state  <= FAULT;
                    r_locked <= 1'b0;
                    r_error  <= 1'b1;
                end else begin
                    case (r_state)
                        IDLE: begin
                            r_state <= SYNC;
                            r_good  <= 3'd0;
                        end
                        SYNC: begin
                            // Wraps help establish lock but are not laps yet.
                            if (w_is_adv || w_is_wrap) begin
                                r_good <= w_good_inc;
                                if (w_good_inc == LOCK_N_W) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end else if (w_is_hold) begin
                                r_good <= r_good;
                            end
                        end
                        LOCKED: begin
                            if (w_is_wrap) begin
                                r_lap_pulse <= 1'b1;
                                if (r_lap_count != {LAP_W{1'b1}}) begin
                                    r_lap_count <= r_lap_count + 1'b1;
                                end
                            end
                        end
                        default: begin
                            // FAULT: samples are ignored until clear/reset.
                            r_state <= FAULT;
                        end
                    endcase
                end
            end
        end
    end

    assign locked    = r_locked;
    assign error     = r_error;
    assign lap_pulse = r_lap_pulse;
    assign lap_count = r_lap_count;

`ifdef EVEN_CHK_CAPTURE_EN
    logic [3:0] r_err_prev;
    logic [3:0] r_err_curr;
    logic [3:0] w_fault_prev;

    // An invalid first sample has no predecessor; record it against 0.
    assign w_fault_prev = (r_state == IDLE) ? 4'd0 : r_prev;

    // Entry to FAULT happens once per clear/reset, so the first fault sticks.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_err_prev <= 4'd0;
            r_err_curr <= 4'd0;
        end else if (w_to_fault) begin
            r_err_prev <= w_fault_prev;
            r_err_curr <= cnt_in;
        end
    end

    assign err_prev = r_err_prev;
    assign err_curr = r_err_curr;
`endif

endmodule

// File: tb/tb_even_count_checker.sv
// -----------------------------------------------------------------------------
// tb_even_count_checker
// Directed bench for even_count_checker (LAP_W=2 so saturation is reachable).
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, i.e. one cycle after the sample edge.
// -----------------------------------------------------------------------------
module tb_even_count_checker;

    localparam int LAP_W = 2;

    logic             clk;
    logic             reset;
    logic             cnt_valid;
    logic [3:0]       cnt_in;
    logic             clear;
    logic             locked;
    logic             error;
    logic             lap_pulse;
    logic [LAP_W-1:0] lap_count;
`ifdef EVEN_CHK_CAPTURE_EN
    logic [3:0]       err_prev;
    logic [3:0]       err_curr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    even_count_checker #(
        .LAP_W   (LAP_W),
        .MAX_VAL (14),
        .STEP    (2),
        .LOCK_N  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_valid (cnt_valid),
        .cnt_in    (cnt_in),
        .clear     (clear),
        .locked    (locked),
        .error     (error),
        .lap_pulse (lap_pulse),
        .lap_count (lap_count)
`ifdef EVEN_CHK_CAPTURE_EN
        ,
        .err_prev  (err_prev),
        .err_curr  (err_curr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs (called at a falling edge) and return at the
    // next falling edge, after the DUT has registered the result.
    task automatic drive(input logic v, input logic [3:0] val, input logic clr,
                         input logic rst);
        cnt_valid = v;
        cnt_in    = val;
        clear     = clr;
        reset     = rst;
        @(negedge clk);
        $display("t=%0t rst=%0b clr=%0b valid=%0b cnt=%0d -> locked=%0b error=%0b pulse=%0b laps=%0d",
                 $time, rst, clr, v, val, locked, error, lap_pulse, lap_count);
    endtask

    task automatic smp(input logic [3:0] val);
        drive(1'b1, val, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic exp_lock,
                             input logic exp_err, input logic exp_pulse,
                             input logic [LAP_W-1:0] exp_laps);
        check_eq({tag, ".locked"},    32'(locked),    32'(exp_lock));
        check_eq({tag, ".error"},     32'(error),     32'(exp_err));
        check_eq({tag, ".lap_pulse"}, 32'(lap_pulse), 32'(exp_pulse));
        check_eq({tag, ".lap_count"}, 32'(lap_count), 32'(exp_laps));
    endtask

    initial begin
        reset     = 1'b1;
        cnt_valid = 1'b0;
        cnt_in    = 4'd0;
        clear     = 1'b0;
        @(negedge clk);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        check_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);

        // Lock: 0 (IDLE), 2 (good=1), 4 (good=2 -> LOCKED)
        smp(4'd0);  check_out("lock_s0", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd2);  check_out("lock_s2", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd4);  check_out("lock_s4", 1'b1, 1'b0, 1'b0, 2'd0);
        smp(4'd6);  check_out("lock_s6", 1'b1, 1'b0, 1'b0, 2'd0);

        // First lap
        for (int v = 8; v <= 14; v += 2) smp(4'(v));
        check_out("lap1_at14", 1'b1, 1'b0, 1'b0, 2'd0);
        smp(4'd0);  check_out("lap1_wrap", 1'b1, 1'b0, 1'b1, 2'd1);
        smp(4'd2);  check_out("lap1_after", 1'b1, 1'b0, 1'b0, 2'd1);

        // Second lap with a hold on 14 before the wrap
        for (int v = 4; v <= 14; v += 2) smp(4'(v));
        smp(4'd14); check_out("hold14", 1'b1, 1'b0, 1'b0, 2'd1);
        smp(4'd0);  check_out("lap2_wrap", 1'b1, 1'b0, 1'b1, 2'd2);

        // Gap of three invalid cycles (garbage on cnt_in) between 6 and 8
        smp(4'd2); smp(4'd4); smp(4'd6);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'd9, 1'b0, 1'b0);
        check_out("gap_idle", 1'b1, 1'b0, 1'b0, 2'd2);
        smp(4'd8);  check_out("gap_resume", 1'b1, 1'b0, 1'b0, 2'd2);

        // Saturation: three more laps, counter pins at 3 but pulses keep firing
        for (int v = 10; v <= 14; v += 2) smp(4'(v));
        smp(4'd0);  check_out("lap3_wrap", 1'b1, 1'b0, 1'b1, 2'd3);
        for (int lap = 4; lap <= 5; lap++) begin
            for (int v = 2; v <= 14; v += 2) smp(4'(v));
            smp(4'd0);  check_out($sformatf("lap%0d_sat", lap), 1'b1, 1'b0, 1'b1, 2'd3);
        end

        // Illegal skip 4 -> 8 while locked
        smp(4'd2); smp(4'd4);
        smp(4'd8);  check_out("skip", 1'b0, 1'b1, 1'b0, 2'd3);
`ifdef EVEN_CHK_CAPTURE_EN
        check_eq("skip.err_prev", 32'(err_prev), 32'd4);
        check_eq("skip.err_curr", 32'(err_curr), 32'd8);
`endif
        smp(4'd10); smp(4'd12);
        check_out("fault_sticky", 1'b0, 1'b1, 1'b0, 2'd3);

        // Clear alone, then an odd first sample
        drive(1'b0, 4'd0, 1'b1, 1'b0);
        check_out("clear", 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef EVEN_CHK_CAPTURE_EN
        check_eq("clear.err_prev", 32'(err_prev), 32'd0);
        check_eq("clear.err_curr", 32'(err_curr), 32'd0);
`endif
        smp(4'd3);  check_out("odd_idle", 1'b0, 1'b1, 1'b0, 2'd0);
`ifdef EVEN_CHK_CAPTURE_EN
        check_eq("odd.err_prev", 32'(err_prev), 32'd0);
        check_eq("odd.err_curr", 32'(err_curr), 32'd3);
`endif
        // clear with a coincident sample: sample dropped, back in IDLE
        drive(1'b1, 4'd0, 1'b1, 1'b0);
        check_out("clear_valid", 1'b0, 1'b0, 1'b0, 2'd0);
        // 4 is only acceptable if it is treated as a fresh IDLE sample
        smp(4'd4);  check_out("post_clear_idle", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd6);  check_out("post_clear_s6", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd8);  check_out("post_clear_lock", 1'b1, 1'b0, 1'b0, 2'd0);
        for (int v = 10; v <= 14; v += 2) smp(4'(v));
        smp(4'd0);  check_out("pre_reset_lap", 1'b1, 1'b0, 1'b1, 2'd1);
        smp(4'd2);

        // Reset mid-lap wipes everything
        drive(1'b1, 4'd4, 1'b0, 1'b1);
        check_out("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0);
        // 12 is a fresh IDLE sample; 14 advance; 0 wrap in SYNC locks, no lap
        smp(4'd12); check_out("rst_idle", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd14); check_out("rst_s14", 1'b0, 1'b0, 1'b0, 2'd0);
        smp(4'd0);  check_out("sync_wrap", 1'b1, 1'b0, 1'b0, 2'd0);
        // Wrap-like overflow 14 -> 0 from a non-terminal value is illegal: 2 -> 0
        smp(4'd2);
        smp(4'd0);  check_out("back_step", 1'b0, 1'b1, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
